word_lock_rx: RTL and testbench
===============================

// Module: word_lock_rx
// PURPOSE
//  Interlaken RX word-lock and 64b/67b decode stage directly downstream of the 20->67 RX gearbox.
//  Consumes 67-bit words {inv[66], hdr[65:64], payload[63:0]} plus valid.
//  Runs the word-lock state machine on the framing header and undoes the payload inversion.
//  Delivers 64-bit words tagged data/control to the descrambler/framer.
// PARAMETERS
//  LOCK_CNT    64  consecutive valid headers required to declare lock
//  ERR_WINDOW  64  valid input words per error-monitoring window while locked
//  ERR_THRESH  16  invalid headers within one window that force loss of lock
// PORTS
//  USER_CLK        in   1   single clock, all logic on rising edge
//  SYSTEM_RESET    in   1   synchronous, active-high reset
//  DATA_IN         in   67  gearbox word: [66]=inversion, [65:64]=header, [63:0]=payload
//  DATA_IN_VALID   in   1   DATA_IN qualifier; gaps allowed on any cycle
//  DATA_OUT        out  64  decoded payload
//  DATA_OUT_CTRL   out  1   1 = control word (hdr 2'b10), 0 = data word (hdr 2'b01)
//  DATA_OUT_VALID  out  1   DATA_OUT/DATA_OUT_CTRL qualifier, single-cycle per word
//  WORD_LOCK       out  1   1 while state == LOCKED
//  LOCK_LOST       out  1   one-cycle pulse on LOCKED->HUNT transition
//  HDR_ERR_CNT     out  16  saturating invalid-header count (only with WORD_LOCK_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0; state=HUNT; good_cnt=0; win_cnt=0; bad_cnt=0.
//  - Reset mid-operation: state and all counters cleared on that edge; no output pulse.
//  - Header valid iff hdr[65] != hdr[64]; hdr 2'b00/2'b11 is invalid.
//  - Counters and state advance only on cycles with DATA_IN_VALID=1.
//    Idle cycles hold all state; DATA_OUT_VALID=0 on idle cycles.
//  - Decode (registered, latency 1 cycle):
//    DATA_OUT = inv ? ~payload : payload; DATA_OUT_CTRL = hdr[65].
//  - DATA_OUT_VALID=1 one cycle after an input word with a valid header, only if
//    WORD_LOCK=1 in the cycle that word is sampled; otherwise 0.
//    DATA_OUT holds its last value when DATA_OUT_VALID=0.
//  - FSM states:
//    HUNT: valid hdr -> good_cnt++; invalid hdr -> good_cnt=0.
//      When good_cnt reaches LOCK_CNT: ->LOCKED, win_cnt=0, bad_cnt=0.
//      The word completing the count is not forwarded; forwarding starts with the next word.
//    LOCKED: every valid input increments win_cnt; invalid hdr increments bad_cnt
//      and the word is dropped.
//      bad_cnt reaching ERR_THRESH -> HUNT, good_cnt=0, LOCK_LOST=1 for 1 cycle,
//      WORD_LOCK=0 on the same edge.
//      win_cnt reaching ERR_WINDOW with bad_cnt<ERR_THRESH -> win_cnt=0, bad_cnt=0,
//      stay LOCKED.
//      Window end and threshold hit on the same word: threshold wins (->HUNT).
//  - Counter widths = $clog2(param+1); no wrap is possible by construction.
//  - No back-pressure: the downstream stage must accept every valid word.
// CONFIGURATION
//  WORD_LOCK_ERR_CNT_EN defined:
//    HDR_ERR_CNT port present; +1 per invalid header in any state, saturates at 16'hFFFF;
//    cleared only by SYSTEM_RESET.
//  WORD_LOCK_ERR_CNT_EN undefined:
//    HDR_ERR_CNT port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset, then 64 valid words hdr=01 inv=0 -> WORD_LOCK rises after 64th; word 65 out, latency 1.
//  2. Locked; input inv=1, payload=64'h0123_4567_89AB_CDEF, hdr=10 ->
//     DATA_OUT=64'hFEDC_BA98_7654_3210, DATA_OUT_CTRL=1.
//  3. Locked; 15 hdr=11 words in one 64-word window -> stay locked, counters clear at window end.
//     16 bad words in one window -> LOCK_LOST pulse, WORD_LOCK=0.
//  4. HUNT; 40 good words, 1 hdr=00, 63 good -> no lock; 1 more good word -> WORD_LOCK=1.
//  5. Locked; toggle DATA_IN_VALID 1/0 every cycle -> state holds on gaps, 1:1 output, no lock loss.
//  6. Assert SYSTEM_RESET while locked with bad_cnt=10 -> all outputs 0 next edge, relock needs full 64.

Source files
------------

// File: rtl/word_lock_rx.sv
// Interlaken RX word lock and 64b/67b decode: hunts for stable framing headers,
// monitors header errors while locked, and forwards de-inverted payload words.
// Optional saturating header-error counter: define WORD_LOCK_ERR_CNT_EN.
module word_lock_rx #(
  parameter int LOCK_CNT   = 64,
  parameter int ERR_WINDOW = 64,
  parameter int ERR_THRESH = 16
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [66:0] DATA_IN,
  input  logic        DATA_IN_VALID,
  output logic [63:0] DATA_OUT,
  output logic        DATA_OUT_CTRL,
  output logic        DATA_OUT_VALID,
  output logic        WORD_LOCK,
  output logic        LOCK_LOST
`ifdef WORD_LOCK_ERR_CNT_EN
  ,
  output logic [15:0] HDR_ERR_CNT
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int BW = $clog2(ERR_THRESH + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  typedef struct packed {
    logic        inv;
    logic [1:0]  hdr;
    logic [63:0] payload;
  } rx_word_t;

  rx_word_t        din;
  logic            hdr_ok;
  state_t          state, state_nxt;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic [WW-1:0]   win_cnt, win_nxt;
  logic [BW-1:0]   bad_cnt, bad_nxt;
  logic            fwd, lost;

  assign din       = rx_word_t'(DATA_IN);
  assign hdr_ok    = din.hdr[1] ^ din.hdr[0];
  assign WORD_LOCK = (state == LOCKED);

  // Counters compare against N-1 so the Nth qualifying word triggers the transition.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    win_nxt   = win_cnt;
    bad_nxt   = bad_cnt;
    fwd       = 1'b0;
    lost      = 1'b0;
    if (DATA_IN_VALID) begin
      case (state)
        HUNT: begin
          if (!hdr_ok) begin
            good_nxt = '0;
          end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
            win_nxt   = '0;
            bad_nxt   = '0;
          end else begin
            good_nxt = good_cnt + GW'(1);
          end
        end
        LOCKED: begin
          fwd = hdr_ok;
          // Threshold takes priority over window end on the same word.
          if (!hdr_ok && bad_cnt == BW'(ERR_THRESH - 1)) begin
            state_nxt = HUNT;
            good_nxt  = '0;
            win_nxt   = '0;
            bad_nxt   = '0;
            lost      = 1'b1;
          end else if (win_cnt == WW'(ERR_WINDOW - 1)) begin
            win_nxt = '0;
            bad_nxt = '0;
          end else begin
            win_nxt = win_cnt + WW'(1);
            bad_nxt = bad_cnt + BW'(!hdr_ok);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state    <= HUNT;
      good_cnt <= '0;
      win_cnt  <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      win_cnt  <= win_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      DATA_OUT       <= '0;
      DATA_OUT_CTRL  <= 1'b0;
      DATA_OUT_VALID <= 1'b0;
      LOCK_LOST      <= 1'b0;
    end else begin
      DATA_OUT_VALID <= fwd;
      LOCK_LOST      <= lost;
      if (fwd) begin
        DATA_OUT      <= din.inv ? ~din.payload : din.payload;
        DATA_OUT_CTRL <= din.hdr[1];
      end
    end
  end

`ifdef WORD_LOCK_ERR_CNT_EN
  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET)
      HDR_ERR_CNT <= '0;
    else if (DATA_IN_VALID && !hdr_ok && HDR_ERR_CNT != 16'hFFFF)
      HDR_ERR_CNT <= HDR_ERR_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_word_lock_rx.sv
// Bench for word_lock_rx: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_word_lock_rx;

  logic        USER_CLK = 1'b0;
  logic        SYSTEM_RESET;
  logic [66:0] DATA_IN;
  logic        DATA_IN_VALID;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_CTRL;
  logic        DATA_OUT_VALID;
  logic        WORD_LOCK;
  logic        LOCK_LOST;
`ifdef WORD_LOCK_ERR_CNT_EN
  logic [15:0] HDR_ERR_CNT;
`endif

  word_lock_rx dut (
    .USER_CLK       (USER_CLK),
    .SYSTEM_RESET   (SYSTEM_RESET),
    .DATA_IN        (DATA_IN),
    .DATA_IN_VALID  (DATA_IN_VALID),
    .DATA_OUT       (DATA_OUT),
    .DATA_OUT_CTRL  (DATA_OUT_CTRL),
    .DATA_OUT_VALID (DATA_OUT_VALID),
    .WORD_LOCK      (WORD_LOCK),
    .LOCK_LOST      (LOCK_LOST)
`ifdef WORD_LOCK_ERR_CNT_EN
    ,
    .HDR_ERR_CNT    (HDR_ERR_CNT)
`endif
  );

  always #5 USER_CLK = ~USER_CLK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: lock status, run of good headers, words and errors in window.
  bit          m_locked;
  int          m_run, m_seen, m_errs, m_hdr_errs;
  bit          e_vld, e_ctrl, e_lost;
  logic [63:0] e_out;
  int          n_out;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] mk(input bit inv, input logic [1:0] hdr, input logic [63:0] p);
    return {inv, hdr, p};
  endfunction

  task automatic model(input bit rst, input bit v, input logic [66:0] w);
    bit          ok;
    logic [63:0] p;
    e_vld  = 0;
    e_lost = 0;
    if (rst) begin
      m_locked = 0; m_run = 0; m_seen = 0; m_errs = 0; m_hdr_errs = 0;
      e_out = '0; e_ctrl = 0;
      return;
    end
    if (!v) return;
    p  = w[63:0];
    ok = (w[65:64] == 2'b01) || (w[65:64] == 2'b10);
    if (!ok && m_hdr_errs < 65535) m_hdr_errs++;
    if (m_locked) begin
      if (ok) begin
        e_vld  = 1;
        e_out  = w[66] ? ~p : p;
        e_ctrl = w[65];
      end
      m_seen++;
      if (!ok) m_errs++;
      if (m_errs >= 16) begin
        m_locked = 0; m_run = 0; e_lost = 1;
      end else if (m_seen >= 64) begin
        m_seen = 0; m_errs = 0;
      end
    end else begin
      m_run = ok ? m_run + 1 : 0;
      if (m_run >= 64) begin
        m_locked = 1; m_seen = 0; m_errs = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [66:0] w);
    bit rst;
    DATA_IN       = w;
    DATA_IN_VALID = v;
    rst = SYSTEM_RESET;
    @(posedge USER_CLK);
    model(rst, v, w);
    #1;
    if (DATA_OUT_VALID) n_out++;
    chk("out_vld", 64'(DATA_OUT_VALID), 64'(e_vld));
    chk("word_lock", 64'(WORD_LOCK), 64'(m_locked));
    chk("lock_lost", 64'(LOCK_LOST), 64'(e_lost));
    chk("data_out", DATA_OUT, e_out);
    chk("ctrl", 64'(DATA_OUT_CTRL), 64'(e_ctrl));
`ifdef WORD_LOCK_ERR_CNT_EN
    chk("hdr_err_cnt", 64'(HDR_ERR_CNT), 64'(m_hdr_errs));
`endif
  endtask

  task automatic do_reset();
    SYSTEM_RESET = 1'b1;
    step(1'b0, '0);
    SYSTEM_RESET = 1'b0;
    chk("rst_vld", 64'(DATA_OUT_VALID), 64'd0);
    chk("rst_lock", 64'(WORD_LOCK), 64'd0);
    chk("rst_data", DATA_OUT, 64'd0);
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, mk(1'($urandom), ($urandom & 1) ? 2'b10 : 2'b01, {$urandom, $urandom}));
  endtask

  logic [63:0] pay;

  initial begin
    SYSTEM_RESET  = 1'b1;
    DATA_IN       = '0;
    DATA_IN_VALID = 1'b0;
    do_reset();

    // 1: lock after exactly 64 good words; 65th forwarded with latency 1
    for (int i = 0; i < 63; i++) step(1'b1, mk(1'b0, 2'b01, 64'(i)));
    chk("t1_not_yet", 64'(WORD_LOCK), 64'd0);
    step(1'b1, mk(1'b0, 2'b01, 64'd63));
    chk("t1_lock", 64'(WORD_LOCK), 64'd1);
    chk("t1_no_fwd64", 64'(DATA_OUT_VALID), 64'd0);
    step(1'b1, mk(1'b0, 2'b01, 64'hA5A5_0000_1111_0065));
    chk("t1_w65_vld", 64'(DATA_OUT_VALID), 64'd1);
    chk("t1_w65_data", DATA_OUT, 64'hA5A5_0000_1111_0065);

    // 2: inverted control word
    step(1'b1, mk(1'b1, 2'b10, 64'h0123_4567_89AB_CDEF));
    chk("t2_data", DATA_OUT, 64'hFEDC_BA98_7654_3210);
    chk("t2_ctrl", 64'(DATA_OUT_CTRL), 64'd1);

    // 3: fresh windows from a new lock; 15 bad twice stays locked, 16 drops
    do_reset();
    good(64);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 64; i++)
        step(1'b1, mk(1'b0, (i % 4 == 1 && i < 60) ? 2'b11 : 2'b01, {$urandom, $urandom}));
    chk("t3_keep_lock", 64'(WORD_LOCK), 64'd1);
    for (int i = 0; i < 15; i++) step(1'b1, mk(1'b0, 2'b11, '0));
    chk("t3_15bad", 64'(WORD_LOCK), 64'd1);
    step(1'b1, mk(1'b0, 2'b00, '0));
    chk("t3_lost_pulse", 64'(LOCK_LOST), 64'd1);
    chk("t3_unlocked", 64'(WORD_LOCK), 64'd0);
    step(1'b0, '0);
    chk("t3_pulse_end", 64'(LOCK_LOST), 64'd0);

    // 4: a bad header restarts the hunt count
    good(40);
    step(1'b1, mk(1'b0, 2'b00, '0));
    good(63);
    chk("t4_no_lock", 64'(WORD_LOCK), 64'd0);
    good(1);
    chk("t4_lock", 64'(WORD_LOCK), 64'd1);

    // 5: alternating gaps while locked
    n_out = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) good(1);
      else step(1'b0, {3'b011, 64'(i)});
    end
    chk("t5_out_count", 64'(n_out), 64'd20);
    chk("t5_lock", 64'(WORD_LOCK), 64'd1);

    // 6: reset with 10 errors pending, relock needs the full count
    for (int i = 0; i < 10; i++) step(1'b1, mk(1'b0, 2'b11, '0));
    do_reset();
    good(63);
    chk("t6_no_lock", 64'(WORD_LOCK), 64'd0);
    good(1);
    chk("t6_relock", 64'(WORD_LOCK), 64'd1);

    // Random traffic with phases of low and high header error rates
    for (int ph = 0; ph < 24; ph++) begin
      int bad_pct;
      bad_pct = (ph % 3 == 2) ? 35 : ((ph % 3 == 1) ? 8 : 1);
      for (int i = 0; i < 150; i++) begin
        logic [1:0] h;
        if ($urandom_range(99) < bad_pct) h = ($urandom & 1) ? 2'b11 : 2'b00;
        else h = ($urandom & 1) ? 2'b10 : 2'b01;
        pay = {$urandom, $urandom};
        step(($urandom_range(3) != 0), mk(1'($urandom), h, pay));
      end
      if (ph == 11) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
